chdr_strs_generator: RTL and testbench
======================================

CHDR_STRS_GENERATOR -- requirements
Module: chdr_strs_generator

Interface
REQ-001 Parameter CHDR_W, default 64, CHDR bus width; only 64 supported.
REQ-002 Parameter BUFF_SIZE, default 11, log2 of ingress buffer depth in CHDR_W words.
REQ-003 Parameter CAP_PKTS, default 24'hFFFFFF, advertised packet capacity.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cfg_start  in  1  one-cycle stream-init pulse.
REQ-007 cfg_this_epid / cfg_dst_epid  in  16 each  source EPID (reported) / destination EPID (header).
REQ-008 cfg_fc_freq_bytes  in  40  byte threshold for a status report; 0 disables.
REQ-009 cfg_fc_freq_pkts  in  24  packet threshold for a status report; 0 disables.
REQ-010 rx_pkt_stb  in  1  one packet consumed from the ingress buffer.
REQ-011 rx_pkt_bytes  in  16  byte length of that packet, valid with rx_pkt_stb.
REQ-012 seq_err_stb / data_err_stb  in  1 each  sequence / data error pulses.
REQ-013 m_axis_strs_tdata/tlast/tvalid/tready  out/out/out/in  64/1/1/1  stream-status output, AXI-Stream.

Function
REQ-014 Each status packet SHALL be 5 words: header, P0..P3; tlast on P3 only.
REQ-015 Header SHALL be {vc 6'h0, eob 0, eov 0, pkt_type 3'd0, num_mdata 5'd0, seqnum[15:0], length 16'd40, cfg_dst_epid}, fields MSB-first.
REQ-016 P0 = {CAP_PKTS[23:0], cap_bytes[39:0]}, cap_bytes = 2^BUFF_SIZE*8 (16384 at default).
REQ-017 P1 = {24'h0, xfer_pkts[39:0]}; P2 = xfer_bytes[63:0]; P3 = {44'h0, status[3:0], cfg_this_epid}.
REQ-018 status codes: 0 OK, 2 SEQERR, 3 DATAERR; latest error since last report wins; data over seq on same cycle.
REQ-019 xfer_pkts/xfer_bytes SHALL be cumulative, incremented on rx_pkt_stb by 1 / rx_pkt_bytes, wrapping modulo 2^40 / 2^64.
REQ-020 Since-report counters acc_pkts (24b) and acc_bytes (40b) SHALL increment likewise and saturate at all-ones.
REQ-021 Trigger pending SHALL set when (freq_pkts!=0 and acc_pkts>=freq_pkts) or (freq_bytes!=0 and acc_bytes>=freq_bytes), or on any error strobe, or on cfg_start.
REQ-022 FSM states IDLE, HDR, P0, P1, P2, P3; IDLE->HDR the cycle after pending is seen; each state advances only on tvalid&tready; P3 accepted ->IDLE.
REQ-023 On IDLE->HDR, the module SHALL snapshot xfer counters and status into the packet registers, clear pending, and load acc counters with the current-cycle increment (0 if no rx_pkt_stb).
REQ-024 Snapshot SHALL use pre-increment values; a same-cycle rx_pkt_stb counts in the next report.
REQ-025 tvalid SHALL be high throughout HDR..P3; tdata/tlast SHALL hold stable while tvalid&!tready.
REQ-026 seqnum SHALL increment by 1 per packet completed (P3 accepted), wrapping at 16 bits.
REQ-027 Triggers during HDR..P3 SHALL latch pending; at most one further report follows, with no intermediate IDLE cycle beyond one.
REQ-028 cfg_start SHALL clear xfer, acc, seqnum, status to 0 and set pending; if a packet is in flight it SHALL complete with its snapshot, then the init report (all counters 0) follows.
REQ-029 Latency: trigger cycle N -> header tvalid at cycle N+2 when IDLE and tready high.

Reset
REQ-030 rst SHALL asynchronously force FSM to IDLE, tvalid 0, tlast 0, tdata 0, all counters, seqnum, status and pending to 0.
REQ-031 Reset mid-packet SHALL abort the packet; no partial packet resumes after release.

Structure
REQ-032 Shared package chdr_strs_pkg SHALL hold pkt_type constant, status codes, header field offsets/widths, STRS_LEN_BYTES=40 and the FSM state enum.
REQ-033 No sub-module; output is driven directly from the FSM's registered word mux.

Verification
REQ-034 freq_pkts=10, freq_bytes=0, ten 200-byte rx strobes -> one packet, seqnum 0, P1=10, P2=2000, status 0, length 40, dst 16'hBEEF.
REQ-035 freq_bytes=800, freq_pkts=0, four 200-byte strobes -> report after 4th with P2=800; fifth strobe on snapshot cycle appears only in next report.
REQ-036 Hold tready low 20 cycles mid-packet -> tvalid held, tdata/tlast unchanged, FSM stays; 5 beats total after release.
REQ-037 seq_err_stb in IDLE -> report with status 2; simultaneous seq+data -> status 3.
REQ-038 cfg_start during P1 -> current packet completes, next packet has seqnum 0, P1=P2=0, status 0.
REQ-039 Assert rst during P2 -> tvalid low asynchronously, no trailing beats; post-reset first report has seqnum 0.

Source files
------------

// File: rtl/chdr_strs_pkg.sv
// chdr_strs_pkg: constants, status codes, header layout and FSM states for the CHDR stream-status generator.
package chdr_strs_pkg;
    localparam logic [2:0]  PKT_TYPE_STRS  = 3'd0;
    localparam logic [15:0] STRS_LEN_BYTES = 16'd40;
    localparam int HDR_DST_LSB  = 0;
    localparam int HDR_LEN_LSB  = 16;
    localparam int HDR_SEQ_LSB  = 32;
    localparam int HDR_NMD_LSB  = 48;
    localparam int HDR_TYPE_LSB = 53;
    localparam int HDR_EOV_LSB  = 56;
    localparam int HDR_EOB_LSB  = 57;
    localparam int HDR_VC_LSB   = 58;
    localparam int HDR_VC_W     = 6;
    localparam int HDR_NMD_W    = 5;

    typedef enum logic [3:0] {
        STS_OK      = 4'd0,
        STS_CMDERR  = 4'd1,
        STS_SEQERR  = 4'd2,
        STS_DATAERR = 4'd3
    } status_e;

    typedef enum logic [2:0] {IDLE, HDR, P0, P1, P2, P3} state_e;

    function automatic logic [63:0] strs_hdr(input logic [15:0] seq, input logic [15:0] dst);
        return (64'({HDR_VC_W{1'b0}}) << HDR_VC_LSB) | (64'(1'b0) << HDR_EOB_LSB)
             | (64'(1'b0) << HDR_EOV_LSB) | (64'(PKT_TYPE_STRS) << HDR_TYPE_LSB)
             | (64'({HDR_NMD_W{1'b0}}) << HDR_NMD_LSB) | (64'(seq) << HDR_SEQ_LSB)
             | (64'(STRS_LEN_BYTES) << HDR_LEN_LSB) | (64'(dst) << HDR_DST_LSB);
    endfunction
endpackage

// File: rtl/chdr_strs_generator_if.sv
// chdr_strs_generator_if: AXI-Stream carrying stream-status packets.
interface chdr_strs_generator_if #(parameter int W = 64);
    logic [W-1:0] tdata;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    modport master(output tdata, tlast, tvalid, input tready);
    modport slave(input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/chdr_strs_generator.sv
// chdr_strs_generator: counts consumed ingress packets/bytes and emits 5-word CHDR stream-status
// reports on flow-control thresholds, error strobes or stream init.
module chdr_strs_generator
    import chdr_strs_pkg::*;
#(
    parameter int          CHDR_W    = 64,
    parameter int          BUFF_SIZE = 11,
    parameter logic [23:0] CAP_PKTS  = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    input  logic [15:0] cfg_this_epid,
    input  logic [15:0] cfg_dst_epid,
    input  logic [39:0] cfg_fc_freq_bytes,
    input  logic [23:0] cfg_fc_freq_pkts,
    input  logic        rx_pkt_stb,
    input  logic [15:0] rx_pkt_bytes,
    input  logic        seq_err_stb,
    input  logic        data_err_stb,
    chdr_strs_generator_if.master m_axis_strs
);
    localparam logic [39:0] CAP_BYTES = 40'd1 << (BUFF_SIZE + 3);

    state_e            state_q, state_d;
    logic              pending_q, pending_d;
    logic              restart_q, restart_d;
    logic [39:0]       xfer_pkts_q, xfer_pkts_d, snap_pkts_q, snap_pkts_d;
    logic [63:0]       xfer_bytes_q, xfer_bytes_d, snap_bytes_q, snap_bytes_d;
    logic [23:0]       acc_pkts_q, acc_pkts_d, pkts_inc, pkts_sum;
    logic [39:0]       acc_bytes_q, acc_bytes_d, bytes_inc, bytes_sum;
    logic              pkts_c, bytes_c;
    logic [15:0]       seqnum_q, seqnum_d;
    status_e           status_q, status_d, snap_status_q, snap_status_d;
    logic [CHDR_W-1:0] tdata_q, tdata_d, word_d;
    logic              go, adv, p3_done, trig;

    always_comb begin
        go       = state_q == IDLE && pending_q;
        adv      = state_q != IDLE && m_axis_strs.tready;
        p3_done  = state_q == P3 && m_axis_strs.tready;
        state_d  = go ? HDR : !adv ? state_q : state_q == P3 ? IDLE : state_e'(state_q + 3'd1);
        pkts_inc = {23'd0, rx_pkt_stb};
        bytes_inc = rx_pkt_stb ? {24'd0, rx_pkt_bytes} : 40'd0;
        {pkts_c, pkts_sum}   = {1'b0, acc_pkts_q} + {1'b0, pkts_inc};
        {bytes_c, bytes_sum} = {1'b0, acc_bytes_q} + {1'b0, bytes_inc};
        acc_pkts_d   = cfg_start ? '0 : go ? pkts_inc : pkts_c ? '1 : pkts_sum;
        acc_bytes_d  = cfg_start ? '0 : go ? bytes_inc : bytes_c ? '1 : bytes_sum;
        xfer_pkts_d  = cfg_start ? '0 : xfer_pkts_q + 40'(rx_pkt_stb);
        xfer_bytes_d = cfg_start ? '0 : xfer_bytes_q + 64'(bytes_inc);
        trig = (cfg_fc_freq_pkts != '0 && acc_pkts_d >= cfg_fc_freq_pkts)
            || (cfg_fc_freq_bytes != '0 && acc_bytes_d >= cfg_fc_freq_bytes)
            || seq_err_stb || data_err_stb || cfg_start;
        pending_d = trig || (pending_q && !go);
        status_d  = data_err_stb ? STS_DATAERR : seq_err_stb ? STS_SEQERR
                  : (go || cfg_start) ? STS_OK : status_q;
        // An init arriving mid-packet restarts numbering at 0 for the packet that follows.
        restart_d = cfg_start && (state_q != IDLE || go) ? 1'b1 : p3_done ? 1'b0 : restart_q;
        seqnum_d  = cfg_start ? '0 : p3_done && !restart_q ? seqnum_q + 16'd1 : seqnum_q;
        snap_pkts_d   = go ? xfer_pkts_q : snap_pkts_q;
        snap_bytes_d  = go ? xfer_bytes_q : snap_bytes_q;
        snap_status_d = go ? status_q : snap_status_q;
        word_d = state_d == HDR ? strs_hdr(seqnum_q, cfg_dst_epid)
               : state_d == P0  ? {CAP_PKTS, CAP_BYTES}
               : state_d == P1  ? {24'h0, snap_pkts_q}
               : state_d == P2  ? snap_bytes_q
               : state_d == P3  ? {44'h0, snap_status_q, cfg_this_epid} : '0;
        tdata_d = (go || adv) ? word_d : tdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            restart_q     <= 1'b0;
            xfer_pkts_q   <= '0;
            xfer_bytes_q  <= '0;
            acc_pkts_q    <= '0;
            acc_bytes_q   <= '0;
            snap_pkts_q   <= '0;
            snap_bytes_q  <= '0;
            seqnum_q      <= '0;
            status_q      <= STS_OK;
            snap_status_q <= STS_OK;
            tdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            restart_q     <= restart_d;
            xfer_pkts_q   <= xfer_pkts_d;
            xfer_bytes_q  <= xfer_bytes_d;
            acc_pkts_q    <= acc_pkts_d;
            acc_bytes_q   <= acc_bytes_d;
            snap_pkts_q   <= snap_pkts_d;
            snap_bytes_q  <= snap_bytes_d;
            seqnum_q      <= seqnum_d;
            status_q      <= status_d;
            snap_status_q <= snap_status_d;
            tdata_q       <= tdata_d;
        end
    end

    assign m_axis_strs.tdata  = tdata_q;
    assign m_axis_strs.tvalid = state_q != IDLE;
    assign m_axis_strs.tlast  = state_q == P3;
endmodule

// File: tb/tb_chdr_strs_generator.sv
// tb_chdr_strs_generator: directed checks of status reports, thresholds, errors, back-pressure, init and reset.
module tb_chdr_strs_generator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [15:0] cfg_this_epid = 16'h1234;
    logic [15:0] cfg_dst_epid = 16'hBEEF;
    logic [39:0] cfg_fc_freq_bytes = '0;
    logic [23:0] cfg_fc_freq_pkts = 24'd10;
    logic        rx_pkt_stb = 1'b0;
    logic [15:0] rx_pkt_bytes = '0;
    logic        seq_err_stb = 1'b0;
    logic        data_err_stb = 1'b0;
    logic        tready = 1'b0;
    logic [63:0] exp_w [5];
    int          checks = 0;
    int          failures = 0;

    chdr_strs_generator_if #(.W(64)) strs();
    assign strs.tready = tready;

    chdr_strs_generator dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_this_epid(cfg_this_epid), .cfg_dst_epid(cfg_dst_epid),
        .cfg_fc_freq_bytes(cfg_fc_freq_bytes), .cfg_fc_freq_pkts(cfg_fc_freq_pkts),
        .rx_pkt_stb(rx_pkt_stb), .rx_pkt_bytes(rx_pkt_bytes),
        .seq_err_stb(seq_err_stb), .data_err_stb(data_err_stb),
        .m_axis_strs(strs)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_exp(input logic [15:0] seq, input logic [39:0] p1, input logic [63:0] p2, input logic [3:0] st);
        exp_w[0] = {16'h0000, seq, 16'h0028, 16'hBEEF};
        exp_w[1] = 64'hFFFFFF_0000004000;
        exp_w[2] = {24'h0, p1};
        exp_w[3] = p2;
        exp_w[4] = {44'h0, st, 16'h1234};
    endtask

    task automatic send_rx(input logic [15:0] b);
        rx_pkt_stb = 1'b1;
        rx_pkt_bytes = b;
        tick;
        rx_pkt_stb = 1'b0;
    endtask

    task automatic pulse_err(input logic s, input logic d);
        seq_err_stb = s;
        data_err_stb = d;
        tick;
        seq_err_stb = 1'b0;
        data_err_stb = 1'b0;
    endtask

    task automatic get_pkt(input int stall_at, input int start_at, input int rst_at);
        int n = 0;
        int guard = 0;
        int bad;
        while (n < 5 && guard < 100) begin
            if (strs.tvalid) begin
                if (n == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_tvalid", 64'(strs.tvalid), 64'd0);
                    chk("rst_tdata", strs.tdata, 64'd0);
                    tick;
                    rst = 1'b0;
                    bad = 0;
                    repeat (8) begin
                        tick;
                        if (strs.tvalid) bad++;
                    end
                    chk("no_trailing_beats", 64'(bad), 64'd0);
                    return;
                end
                if (n == stall_at) begin
                    tready = 1'b0;
                    bad = 0;
                    repeat (20) begin
                        tick;
                        if (!strs.tvalid || strs.tlast || strs.tdata !== exp_w[n]) bad++;
                    end
                    chk("stall_hold", 64'(bad), 64'd0);
                end
                tready = 1'b1;
                cfg_start = (n == start_at);
                chk($sformatf("beat%0d_data", n), strs.tdata, exp_w[n]);
                chk($sformatf("beat%0d_last", n), 64'(strs.tlast), 64'(n == 4));
                tick;
                cfg_start = 1'b0;
                tready = 1'b0;
                n++;
            end else begin
                tick;
                guard++;
            end
        end
        chk("pkt_beats", 64'(n), 64'd5);
    endtask

    initial begin
        repeat (3) tick;
        chk("reset_tvalid", 64'(strs.tvalid), 64'd0);
        chk("reset_tlast", 64'(strs.tlast), 64'd0);
        chk("reset_tdata", strs.tdata, 64'd0);
        rst = 1'b0;
        tick;
        // Packet-count threshold: ten 200-byte packets
        repeat (10) send_rx(16'd200);
        chk("latency_n1", 64'(strs.tvalid), 64'd0);
        tick;
        chk("latency_n2", 64'(strs.tvalid), 64'd1);
        set_exp(16'd0, 40'd10, 64'd2000, 4'd0);
        get_pkt(-1, -1, -1);
        chk("idle_after_pkt", 64'(strs.tvalid), 64'd0);
        // Init report with all counters cleared
        cfg_fc_freq_pkts = '0;
        cfg_fc_freq_bytes = 40'd800;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
        set_exp(16'd0, 40'd0, 64'd0, 4'd0);
        get_pkt(-1, -1, -1);
        // Byte threshold; fifth packet lands on the snapshot cycle
        repeat (4) send_rx(16'd200);
        send_rx(16'd200);
        set_exp(16'd1, 40'd4, 64'd800, 4'd0);
        get_pkt(-1, -1, -1);
        pulse_err(1'b1, 1'b0);
        set_exp(16'd2, 40'd5, 64'd1000, 4'd2);
        get_pkt(-1, -1, -1);
        pulse_err(1'b1, 1'b1);
        set_exp(16'd3, 40'd5, 64'd1000, 4'd3);
        get_pkt(-1, -1, -1);
        // Back-pressure on P1
        pulse_err(1'b1, 1'b0);
        set_exp(16'd4, 40'd5, 64'd1000, 4'd2);
        get_pkt(2, -1, -1);
        // Init during P1: in-flight packet completes, then init report
        pulse_err(1'b1, 1'b0);
        set_exp(16'd5, 40'd5, 64'd1000, 4'd2);
        get_pkt(-1, 2, -1);
        set_exp(16'd0, 40'd0, 64'd0, 4'd0);
        get_pkt(-1, -1, -1);
        // Reset during P2 aborts the packet
        pulse_err(1'b1, 1'b0);
        set_exp(16'd1, 40'd0, 64'd0, 4'd2);
        get_pkt(-1, -1, 3);
        pulse_err(1'b1, 1'b0);
        set_exp(16'd0, 40'd0, 64'd0, 4'd2);
        get_pkt(-1, -1, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
